// File: rtl/fme_pkg.sv
// Shared constants and state encoding for the fractional motion-estimation clip path.
package fme_pkg;

   localparam int unsigned DATAWIDTH = 8;
   localparam int unsigned FILL_ROWS = 7;
   localparam int unsigned MAX_ROWS  = 16;
   localparam int unsigned ROW_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } fme_state_e;

endpackage

// File: rtl/fme_clip_ctrl.sv
// Row sequencer for the interpolation clip stage: primes the filter, tags output rows,
// honours sink backpressure and reports block completion.
module fme_clip_ctrl #(
   parameter int unsigned MAX_ROWS  = fme_pkg::MAX_ROWS,
   parameter int unsigned FILL_ROWS = fme_pkg::FILL_ROWS,
   parameter int unsigned ROW_W     = fme_pkg::ROW_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [ROW_W-1:0] blk_h,
   input  logic             abort,
   input  logic             src_valid,
   output logic             src_ready,
   output logic             clip_enable,
   output logic             out_valid,
   output logic [ROW_W-1:0] out_row,
   input  logic             dst_ready,
   output logic             busy,
   output logic             done
);

   import fme_pkg::*;

   // Index of the last priming row; unused when there are no priming rows.
   localparam logic [ROW_W-1:0] FILL_LAST = (FILL_ROWS == 0) ? '0 : ROW_W'(FILL_ROWS - 1);
   localparam logic [ROW_W-1:0] MAX_H     = ROW_W'(MAX_ROWS);

   fme_state_e       state_q, state_d;
   logic [ROW_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] h_q, h_d;
   logic             out_valid_q, out_valid_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;
   logic             done_q, done_d;
   logic [ROW_W-1:0] h_clamp;

   // Handshake towards the fetcher and the clip stage enable.
   always_comb begin
      src_ready   = ((state_q == ST_FILL) || (state_q == ST_RUN)) && (!out_valid_q || dst_ready);
      clip_enable = src_valid && src_ready;
      h_clamp     = (blk_h > MAX_H) ? MAX_H : blk_h;
   end

   // Next-state, row counter and output-tag logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      h_d         = h_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      done_d      = 1'b0;

      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_row_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (h_clamp == '0) begin
                     done_d = 1'b1;
                  end else begin
                     h_d     = h_clamp;
                     cnt_d   = '0;
                     state_d = (FILL_ROWS == 0) ? ST_RUN : ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               if (out_valid_q && dst_ready) begin
                  out_valid_d = 1'b0;
               end
               if (clip_enable) begin
                  if (cnt_q == FILL_LAST) begin
                     state_d = ST_RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ROW_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (clip_enable) begin
                  out_valid_d = 1'b1;
                  out_row_d   = cnt_q;
                  cnt_d       = cnt_q + ROW_W'(1);
                  if (cnt_q == (h_q - ROW_W'(1))) begin
                     state_d = ST_DRAIN;
                  end
               end else if (dst_ready) begin
                  out_valid_d = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!out_valid_q || dst_ready) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         h_q         <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         h_q         <= h_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_fme_clip_ctrl.sv
// Bench for fme_clip_ctrl: cycle model plus output-row scoreboard.
module tb_fme_clip_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       src_valid = 1'b0;
   logic       dst_ready = 1'b0;
   logic [4:0] blk_h = 5'd0;
   logic       src_ready, clip_enable, out_valid, busy, done;
   logic [4:0] out_row;

   always #5 clock = ~clock;

   fme_clip_ctrl dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .blk_h       (blk_h),
      .abort       (abort),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .clip_enable (clip_enable),
      .out_valid   (out_valid),
      .out_row     (out_row),
      .dst_ready   (dst_ready),
      .busy        (busy),
      .done        (done)
   );

   int checks = 0;
   int failures = 0;

   // Model state: 0 idle, 1 fill, 2 run, 3 drain.
   int m_st = 0, m_cnt = 0, m_h = 0, m_row = 0;
   bit m_ov = 1'b0, m_done = 1'b0;
   int exp_q[$];

   // Per-block statistics gathered from the DUT.
   int cyc = 0, en_cnt = 0, hs_cnt = 0, done_cnt = 0;
   int en_first = -1, en_last = -1, done_cyc = -1, ov_first = -1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_st = 0; m_cnt = 0; m_h = 0; m_row = 0; m_ov = 1'b0; m_done = 1'b0;
      exp_q.delete();
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input bit sv, input bit dr, input bit st, input bit ab, input int bh);
      bit e_rdy, e_en, nd;
      int h;
      @(negedge clock);
      src_valid = sv; dst_ready = dr; start = st; abort = ab; blk_h = 5'(bh);
      #1;
      if (st && m_st == 0) begin
         cyc = 0; en_cnt = 0; hs_cnt = 0; done_cnt = 0;
         en_first = -1; en_last = -1; done_cyc = -1; ov_first = -1;
      end
      e_rdy = (m_st == 1 || m_st == 2) && (!m_ov || dr);
      e_en  = sv && e_rdy;
      check_eq("src_ready", int'(src_ready), int'(e_rdy));
      check_eq("clip_enable", int'(clip_enable), int'(e_en));
      check_eq("out_valid", int'(out_valid), int'(m_ov));
      check_eq("busy", int'(busy), int'(m_st != 0));
      check_eq("done", int'(done), int'(m_done));
      if (m_ov) check_eq("out_row", int'(out_row), m_row);

      if (clip_enable) begin
         en_cnt++;
         if (en_first < 0) en_first = cyc;
         en_last = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (out_valid && ov_first < 0) ov_first = cyc;
      if (out_valid && dst_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
         else check_eq("sb_row", int'(out_row), exp_q.pop_front());
      end

      nd = 1'b0;
      if (ab && m_st != 0) begin
         m_st = 0; m_ov = 1'b0; m_cnt = 0; m_row = 0;
         exp_q.delete();
      end else begin
         case (m_st)
            0: if (st) begin
                  h = (bh > 16) ? 16 : bh;
                  if (h == 0) nd = 1'b1;
                  else begin m_h = h; m_cnt = 0; m_st = 1; end
               end
            1: if (e_en) begin
                  if (m_cnt == 6) begin m_st = 2; m_cnt = 0; end
                  else m_cnt++;
               end
            2: if (e_en) begin
                  m_ov = 1'b1; m_row = m_cnt; exp_q.push_back(m_cnt);
                  if (m_cnt == m_h - 1) m_st = 3;
                  m_cnt++;
               end else if (dr) m_ov = 1'b0;
            default: if (!m_ov || dr) begin m_st = 0; m_ov = 1'b0; nd = 1'b1; end
         endcase
      end
      m_done = nd;
      cyc++;
   endtask

   // Run until the model returns to idle (bounded), then one more cycle to observe done.
   task automatic run_idle(input bit gaps, input int maxc);
      for (int i = 0; i < maxc && m_st != 0; i++) step(gaps ? (i % 2 == 0) : 1'b1, 1'b1, 1'b0, 1'b0, 0);
      if (m_st != 0) check_eq("timeout", m_st, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic check_outputs_zero(input string pfx);
      check_eq({pfx, "_src_ready"}, int'(src_ready), 0);
      check_eq({pfx, "_clip_enable"}, int'(clip_enable), 0);
      check_eq({pfx, "_out_valid"}, int'(out_valid), 0);
      check_eq({pfx, "_out_row"}, int'(out_row), 0);
      check_eq({pfx, "_busy"}, int'(busy), 0);
      check_eq({pfx, "_done"}, int'(done), 0);
   endtask

   initial begin
      // Reset state
      src_valid = 1'b1; dst_ready = 1'b1;
      #12;
      check_outputs_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Nominal flow, h=4
      step(1'b1, 1'b1, 1'b1, 1'b0, 4);
      repeat (14) step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      check_eq("nom_en_total", en_cnt, 11);
      check_eq("nom_en_first", en_first, 1);
      check_eq("nom_en_last", en_last, 11);
      check_eq("nom_ov_first", ov_first, 9);
      check_eq("nom_done_cyc", done_cyc, 13);
      check_eq("nom_handshakes", hs_cnt, 4);
      check_eq("nom_done_cnt", done_cnt, 1);

      // Backpressure: stall three cycles while row 1 is presented
      step(1'b1, 1'b1, 1'b1, 1'b0, 4);
      for (int i = 0; i < 30 && !(m_ov && m_row == 1); i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 0);
         check_eq("bp_row_held", int'(out_row), 1);
      end
      run_idle(1'b0, 30);
      check_eq("bp_handshakes", hs_cnt, 4);
      check_eq("bp_en_total", en_cnt, 11);
      check_eq("bp_done_cnt", done_cnt, 1);

      // Source gaps, h=5
      step(1'b1, 1'b1, 1'b1, 1'b0, 5);
      run_idle(1'b1, 60);
      check_eq("gap_en_total", en_cnt, 12);
      check_eq("gap_handshakes", hs_cnt, 5);

      // Zero height
      step(1'b1, 1'b1, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      check_eq("h0_done_cyc", done_cyc, 1);
      check_eq("h0_en_total", en_cnt, 0);
      check_eq("h0_done_cnt", done_cnt, 1);

      // Height clamped to MAX_ROWS
      step(1'b1, 1'b1, 1'b1, 1'b0, 20);
      run_idle(1'b0, 40);
      check_eq("h20_en_total", en_cnt, 23);
      check_eq("h20_handshakes", hs_cnt, 16);

      // Abort after row 2, then a clean block
      step(1'b1, 1'b1, 1'b1, 1'b0, 6);
      for (int i = 0; i < 30 && !(m_ov && m_row == 2); i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      check_eq("abort_done_cnt", done_cnt, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 3);
      run_idle(1'b0, 30);
      check_eq("post_abort_handshakes", hs_cnt, 3);
      check_eq("post_abort_en_total", en_cnt, 10);

      // Asynchronous reset mid-FILL
      step(1'b1, 1'b1, 1'b1, 1'b0, 4);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      model_clear();
      @(negedge clock);
      reset_n = 1'b1;

      // Start while busy is ignored
      step(1'b1, 1'b1, 1'b1, 1'b0, 4);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 2);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 2);
      run_idle(1'b0, 30);
      check_eq("busy_start_en_total", en_cnt, 11);
      check_eq("busy_start_handshakes", hs_cnt, 4);
      check_eq("busy_start_done_cnt", done_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
